// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one single-port memory between instruction fetch and the MEM stage
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_if_req/i_if_addr/i_if_kill    fetch request, address, redirect kill
//   o_if_rdata/o_if_valid/o_if_stall fetched instruction, completion pulse, stall
//   i_d_req/i_d_we/i_d_size         data request, store enable, access size
//   i_d_addr/i_d_wdata              data address, store data
//   o_d_rdata/o_d_valid/o_d_stall   load data, completion pulse, stall
//   o_mem_req/we/size/addr/wdata    registered memory request
//   i_mem_rdata/i_mem_ack           memory read data and completion
//
// Optional: define RV32_ARB_STARVE_EN to force a fetch grant after STARVE_MAX
// consecutive data grants made while a fetch was waiting.
module rv32_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_if_kill,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_valid,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [1:0]        i_d_size,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_valid,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [1:0]        o_mem_size,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output logic              o_if_stall,
    output logic              o_d_stall
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    logic [1:0]        r_state;
    logic              r_kill;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [1:0]        r_mem_size;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              w_idle;
    logic              w_starve;
    logic              w_grant_d;
    logic              w_grant_i;

    assign w_idle = (r_state == IDLE);

`ifdef RV32_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 2);
    logic [CNT_W-1:0] r_starve_cnt;

    assign w_starve = (r_starve_cnt == CNT_W'(STARVE_MAX));

    // Counts data grants that overtook a waiting fetch; any grant without a
    // waiting fetch, or any fetch grant, restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_starve_cnt <= '0;
        else if (w_grant_i)
            r_starve_cnt <= '0;
        else if (w_grant_d)
            r_starve_cnt <= i_if_req ? r_starve_cnt + 1'b1 : '0;
    end
`else
    // Strict data priority; STARVE_MAX has no role in this build.
    assign w_starve = (STARVE_MAX < 0);
`endif

    // Data belongs to the older instruction and wins ties unless fetch is starved.
    assign w_grant_d = w_idle & i_d_req & ~(w_starve & i_if_req);
    assign w_grant_i = w_idle & i_if_req & (~i_d_req | w_starve);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_kill      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_size  <= 2'b00;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant_d) begin
            r_state     <= GNT_D;
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_d_we;
            r_mem_size  <= i_d_size;
            r_mem_addr  <= i_d_addr;
            r_mem_wdata <= i_d_wdata;
        end else if (w_grant_i) begin
            r_state    <= GNT_I;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_size <= 2'b10;
            r_mem_addr <= i_if_addr;
        end else if (!w_idle && i_mem_ack) begin
            // Always pass through IDLE so a just-completed request is never regranted.
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_kill    <= 1'b0;
        end else if (r_state == GNT_I && i_if_kill) begin
            // The memory still finishes the stale fetch; only its result is dropped.
            r_kill <= 1'b1;
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_size  = r_mem_size;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_if_rdata  = i_mem_rdata;
    assign o_d_rdata   = i_mem_rdata;
    assign o_d_valid   = (r_state == GNT_D) & i_mem_ack;
    assign o_if_valid  = (r_state == GNT_I) & i_mem_ack & ~r_kill & ~i_if_kill;
    assign o_if_stall  = i_if_req & ~o_if_valid;
    assign o_d_stall   = i_d_req & ~o_d_valid;
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb_rv32_mem_arbiter: scoreboard bench for the fetch/data memory arbiter
module tb_rv32_mem_arbiter;
    typedef struct packed {
        logic        d;
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic        if_kill = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, d_valid, mem_req, mem_we, mem_ack, if_stall, d_stall;
    logic [1:0]  mem_size;

    int   tests = 0;
    int   fails = 0;
    int   lat = 1;
    int   wcnt;
    logic man_ack = 1'b0;
    txn_t exp_q[$];

    rv32_mem_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_kill(if_kill),
        .o_if_rdata(if_rdata), .o_if_valid(if_valid),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_size(d_size), .i_d_addr(d_addr),
        .i_d_wdata(d_wdata), .o_d_rdata(d_rdata), .o_d_valid(d_valid),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_size(mem_size),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
        .o_if_stall(if_stall), .o_d_stall(d_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'h13 : (a == 32'h100) ? 32'hDEADBEEF : a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: acknowledges after lat cycles of mem_req without ack.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
    end
    assign mem_ack   = man_ack | (mem_req && wcnt == lat);
    assign mem_rdata = mem_val(mem_addr);

    // Scoreboard and request-stability monitor.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_we;
    logic [1:0]  prev_size;
    always @(negedge clk) begin : mon
        txn_t e;
        logic [31:0] rd;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && mem_req) begin
                tests++;
                if ({mem_addr, mem_wdata, mem_we, mem_size} !== {prev_addr, prev_wdata, prev_we, prev_size}) begin
                    fails++;
                    $display("FAIL mem_hold: got addr=%h wdata=%h we=%b size=%b, required addr=%h wdata=%h we=%b size=%b",
                             mem_addr, mem_wdata, mem_we, mem_size, prev_addr, prev_wdata, prev_we, prev_size);
                end
            end
            prev_hold = mem_req && !mem_ack;
            {prev_addr, prev_wdata, prev_we, prev_size} = {mem_addr, mem_wdata, mem_we, mem_size};
            if (if_valid || d_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid: d_valid=%b if_valid=%b addr=%h, required no completion",
                             d_valid, if_valid, mem_addr);
                end else begin
                    e  = exp_q.pop_front();
                    rd = e.d ? d_rdata : if_rdata;
                    if (d_valid !== e.d || if_valid === e.d || mem_addr !== e.addr || mem_we !== e.we ||
                        mem_size !== e.size || (e.we && mem_wdata !== e.wdata) || (!e.we && rd !== e.rdata)) begin
                        fails++;
                        $display("FAIL txn: got d=%b i=%b addr=%h we=%b size=%b wdata=%h rdata=%h, required d=%b addr=%h we=%b size=%b wdata=%h rdata=%h",
                                 d_valid, if_valid, mem_addr, mem_we, mem_size, mem_wdata, rd,
                                 e.d, e.addr, e.we, e.size, e.wdata, e.rdata);
                    end
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input bit d, output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (d ? d_valid : if_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic first_fetch_addr(output logic [31:0] a);
        a = 'x;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if_valid) begin
                a = mem_addr;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            fails++; $display("FAIL reset_req: got req=%b we=%b, required 0 0", mem_req, mem_we);
        end
        tests++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_size !== 2'b00) begin
            fails++; $display("FAIL reset_regs: got addr=%h wdata=%h size=%b, required zeros", mem_addr, mem_wdata, mem_size);
        end
        tests++;
        if (if_valid !== 1'b0 || d_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got if=%b d=%b, required 0 0", if_valid, d_valid);
        end
        step;
        rst_n = 1'b1;
    endtask

    task automatic test_fetch;
        int n;
        lat = 1;
        exp_q.push_back(txn_t'{1'b0, 32'h10, 1'b0, 2'b10, 32'h0, 32'h13});
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        tests++;
        if (if_stall !== 1'b1 || mem_req !== 1'b0) begin
            fails++; $display("FAIL fetch_idle: got stall=%b req=%b, required 1 0", if_stall, mem_req);
        end
        wait_valid(1'b0, n);
        tests++;
        if (n != 2) begin
            fails++; $display("FAIL fetch_latency: got %0d cycles, required 2", n);
        end
        tests++;
        if (if_stall !== 1'b0) begin
            fails++; $display("FAIL fetch_stall: got %b at valid, required 0", if_stall);
        end
        step;
        if_req = 1'b0;
        @(negedge clk);
        tests++;
        if (if_valid !== 1'b0 || mem_req !== 1'b0) begin
            fails++; $display("FAIL fetch_pulse: got valid=%b req=%b, required 0 0", if_valid, mem_req);
        end
        step;
    endtask

    task automatic test_simultaneous;
        lat = 1;
        exp_q.push_back(txn_t'{1'b1, 32'h100, 1'b0, 2'b10, 32'h0, 32'hDEADBEEF});
        exp_q.push_back(txn_t'{1'b0, 32'h20, 1'b0, 2'b10, 32'h0, mem_val(32'h20)});
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h20;
        fork
            begin
                int n;
                wait_valid(1'b1, n);
                tests++;
                if (n < 0) begin fails++; $display("FAIL simul_data: got timeout, required d_valid"); end
                step;
                d_req = 1'b0;
                @(negedge clk);
                tests++;
                if (mem_req !== 1'b0) begin
                    fails++; $display("FAIL simul_idle_gap: got req=%b, required 0", mem_req);
                end
                @(negedge clk);
                tests++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
                    fails++; $display("FAIL simul_fetch_grant: got req=%b addr=%h, required 1 00000020", mem_req, mem_addr);
                end
            end
            begin
                int n;
                wait_valid(1'b0, n);
                tests++;
                if (n < 0) begin fails++; $display("FAIL simul_fetch: got timeout, required if_valid"); end
                step;
                if_req = 1'b0;
            end
        join
    endtask

    task automatic test_store;
        int nv = 0, ns = 0, nh = 0;
        lat = 3;
        exp_q.push_back(txn_t'{1'b1, 32'h203, 1'b1, 2'b00, 32'hAB, 32'h0});
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h203; d_wdata = 32'hAB;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ns += d_stall ? 1 : 0;
            nh += (mem_req && !mem_ack) ? 1 : 0;
            nv += d_valid ? 1 : 0;
            if (d_valid) begin
                step;
                d_req = 1'b0; d_we = 1'b0;
            end
        end
        tests++;
        if (nv != 1) begin fails++; $display("FAIL store_pulses: got %0d, required 1", nv); end
        tests++;
        if (nh != 3) begin fails++; $display("FAIL store_wait: got %0d held cycles, required 3", nh); end
        tests++;
        if (ns != 4) begin fails++; $display("FAIL store_stall: got %0d stall cycles, required 4", ns); end
        tests++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL store_idle: got req=%b, required 0", mem_req); end
        step;
    endtask

    task automatic test_kill;
        logic [31:0] a;
        lat = 3;
        exp_q.push_back(txn_t'{1'b0, 32'h40, 1'b0, 2'b10, 32'h0, mem_val(32'h40)});
        if_req = 1'b1; if_addr = 32'h30;
        @(negedge clk);
        @(negedge clk);
        step;
        if_kill = 1'b1;
        step;
        if_kill = 1'b0; if_addr = 32'h40;
        first_fetch_addr(a);
        tests++;
        if (a !== 32'h40) begin fails++; $display("FAIL kill_next_addr: got %h, required 00000040", a); end
        step;
        if_req = 1'b0;
        lat = 1;
        exp_q.push_back(txn_t'{1'b0, 32'h60, 1'b0, 2'b10, 32'h0, mem_val(32'h60)});
        if_req = 1'b1; if_addr = 32'h50;
        @(negedge clk);
        @(negedge clk);
        step;
        if_kill = 1'b1;
        @(negedge clk);
        tests++;
        if (mem_ack !== 1'b1 || if_valid !== 1'b0) begin
            fails++; $display("FAIL kill_same_cycle: got ack=%b if_valid=%b, required 1 0", mem_ack, if_valid);
        end
        step;
        if_kill = 1'b0; if_addr = 32'h60;
        first_fetch_addr(a);
        tests++;
        if (a !== 32'h60) begin fails++; $display("FAIL kill_same_next: got %h, required 00000060", a); end
        step;
        if_req = 1'b0;
    endtask

    task automatic test_reset_mid;
        lat = 1000;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h80;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mid_drop: got req=%b, required 0", mem_req); end
        d_req = 1'b0;
        step;
        rst_n = 1'b1;
        man_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (d_valid !== 1'b0 || if_valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
                fails++; $display("FAIL reset_mid_late_ack: got d=%b i=%b req=%b addr=%h, required 0 0 0 0",
                                  d_valid, if_valid, mem_req, mem_addr);
            end
        end
        step;
        man_ack = 1'b0;
        lat = 1;
    endtask

    task automatic test_min_latency;
        int n;
        lat = 0;
        exp_q.push_back(txn_t'{1'b1, 32'h104, 1'b0, 2'b10, 32'h0, mem_val(32'h104)});
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h104;
        wait_valid(1'b1, n);
        tests++;
        if (n != 2) begin fails++; $display("FAIL min_latency: got %0d, required 2 (idle then ack)", n); end
        step;
        d_req = 1'b0;
        step;
    endtask

`ifdef RV32_ARB_STARVE_EN
    task automatic test_starve;
        int nd = 0;
        bit done = 1'b0;
        lat = 0;
        for (int k = 0; k < 4; k++)
            exp_q.push_back(txn_t'{1'b1, 32'h300 + 32'(4 * k), 1'b0, 2'b10, 32'h0, mem_val(32'h300 + 32'(4 * k))});
        exp_q.push_back(txn_t'{1'b0, 32'h70, 1'b0, 2'b10, 32'h0, mem_val(32'h70)});
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h300;
        if_req = 1'b1; if_addr = 32'h70;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (d_valid) begin
                nd++;
                step;
                d_addr = d_addr + 32'd4;
            end else if (if_valid) begin
                done = 1'b1;
                step;
                if_req = 1'b0; d_req = 1'b0;
            end
        end
        tests++;
        if (!done || nd != 4) begin
            fails++; $display("FAIL starve_grants: got %0d data grants (fetch seen=%b), required 4 (1)", nd, done);
        end
        step;
    endtask
`endif

    initial begin
        test_reset;
        test_fetch;
        test_simultaneous;
        test_store;
        test_kill;
        test_reset_mid;
        test_min_latency;
`ifdef RV32_ARB_STARVE_EN
        test_starve;
`endif
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL leftover: got %0d pending completions, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch (IF) stage and the MEM stage (loads/stores) of the rv32 5-stage pipeline.
- Arbitrates between the two requesters and sequences each memory transaction with a request/acknowledge handshake.
- Returns read data to the winning requester and produces stall signals for the pipeline hazard logic.
- Includes a fetch-kill path so a branch redirect discards an in-flight, stale fetch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, maximum consecutive data grants while a fetch waits. Used only with RV32_ARB_STARVE_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_kill  in  1  branch/jump redirect; discards any outstanding fetch
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  fetch complete, one-cycle pulse
- d_req  in  1  data request; held high until d_valid
- d_we  in  1  1 = store, 0 = load (the MemRW control bit)
- d_size  in  2  00 = byte, 01 = half, 10 = word (the MemSize control field)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_valid  out  1  data access complete, one-cycle pulse
- mem_req  out  1  memory request, registered
- mem_we  out  1  registered
- mem_size  out  2  registered; 10 for fetches
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  transaction complete; may arrive in the same cycle mem_req rises or any later cycle
- if_stall  out  1  if_req & ~if_valid
- d_stall  out  1  d_req & ~d_valid

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D.
- Reset (async, rst_n = 0):
  - State goes to IDLE.
  - mem_req, mem_we, if_valid, d_valid and the kill flag are 0.
  - mem_addr, mem_wdata and mem_size are 0.
  - The starvation counter is 0.
- Reset asserted mid-transaction: mem_req drops immediately. Any mem_ack in flight is ignored after reset releases.
- IDLE:
  - If d_req is high: latch d_addr, d_wdata, d_we and d_size into the mem_* registers, set mem_req = 1, go to GNT_D.
  - Else if if_req is high: latch if_addr, mem_we = 0, mem_size = 10, mem_req = 1, go to GNT_I.
  - Data wins ties because it belongs to the older instruction.
- GNT_x:
  - mem_* registers are held stable while mem_ack is low.
  - On mem_ack: clear mem_req on the next edge and return to IDLE. There is no direct GNT-to-GNT transition, so one IDLE cycle always separates transactions.
- Completion pulses (combinational from mem_ack):
  - d_valid = GNT_D & mem_ack.
  - if_valid = GNT_I & mem_ack & ~kill_flag & ~if_kill.
  - d_rdata and if_rdata pass mem_rdata through. For stores, d_rdata is don't-care.
- Minimum latency: request seen in IDLE at cycle t, mem_req high at t+1, valid at t+1 if mem_ack is high at t+1.
- Requesters drop or replace req in the cycle after valid. The IDLE cycle guarantees the old request is never regranted.
- Kill handling:
  - if_kill in GNT_I sets kill_flag; the fetch completes on the memory side but if_valid is suppressed. kill_flag clears on leaving GNT_I.
  - if_kill in the same cycle as mem_ack in GNT_I suppresses that if_valid.
  - if_kill in IDLE or GNT_D has no effect; the fetch unit simply presents the new if_addr.
- Stores: mem_we = 1 for the whole GNT_D transaction. Sub-word lane alignment is handled by the memory, not this block.

Optional Feature:
- Macro: RV32_ARB_STARVE_EN.
- When defined:
  - A counter increments on each data grant made while if_req is high.
  - The counter resets to 0 on any fetch grant, or when a data grant is made with if_req low.
  - When the counter equals STARVE_MAX, the next IDLE decision grants fetch even if d_req is high.
- When undefined: strict data-over-fetch priority and no counter logic.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x0000_0010, mem_ack one cycle after mem_req with mem_rdata = 0x0000_0013 -> mem_addr = 0x10, mem_size = 10, mem_we = 0; one-cycle if_valid pulse with if_rdata = 0x13; if_stall high until then.
- Simultaneous requests: if_req and d_req (load, addr 0x100, size 10) rise together -> data granted first, d_valid returns 0xDEADBEEF, one IDLE cycle, then fetch granted.
- Store: d_we = 1, d_size = 00, d_addr = 0x203, d_wdata = 0xAB, mem_ack delayed 3 cycles -> mem_* held stable for 3 cycles, d_valid pulses exactly once, then IDLE.
- Kill: if_kill pulses while GNT_I waits on mem_ack, then new if_addr = 0x40 -> no if_valid for the old fetch; the next grant fetches 0x40.
- Reset mid-transaction: rst_n low while mem_req = 1 -> mem_req = 0 immediately; after release the FSM is in IDLE, and a late mem_ack produces no valid.
- STARVE_EN with STARVE_MAX = 4: d_req held high continuously, if_req high -> fetch is granted after exactly 4 data grants.
